// File: rtl/clk_mon_pkg.sv
// clk_monitor shared types and constants: FSM state encoding, default sizing,
// synchroniser depth limits.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_e;

  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned TIMEOUT_CYC_DEF = 32'h0000_FFF0;

  localparam int unsigned SYNC_STAGES_MIN = 2;
  localparam int unsigned SYNC_STAGES_MAX = 4;

  // Force a requested synchroniser depth into the supported range
  function automatic int unsigned clamp_stages(input int unsigned n);
    if (n < SYNC_STAGES_MIN) return SYNC_STAGES_MIN;
    if (n > SYNC_STAGES_MAX) return SYNC_STAGES_MAX;
    return n;
  endfunction

endpackage

// File: rtl/clk_mon_edge_sync.sv
// N-stage synchroniser for an asynchronous input, followed by registered
// single-cycle rise/fall pulses. Input-to-pulse latency is SYNC_STAGES+1.
module clk_mon_edge_sync
  import clk_mon_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);

  localparam int unsigned N = clamp_stages(SYNC_STAGES);

  logic [N-1:0] sync_q, sync_d;
  logic         prev_q, prev_d;
  logic         rise_q, rise_d;
  logic         fall_q, fall_d;

  // Shift the input through the chain and compare last stage against its delayed copy
  always_comb begin
    sync_d = {sync_q[N-2:0], din};
    prev_d = sync_q[N-1];
    rise_d = sync_q[N-1] & ~prev_q;
    fall_d = ~sync_q[N-1] & prev_q;
  end

  // Synchroniser and edge-pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/clk_monitor.sv
// clk_monitor: measures reference period, reference high time and phase lag of
// a second clock, in clk cycles. One result set per reference cycle, flagged by
// a single-cycle meas_valid strobe.
// Optional feature macro CLK_MON_PHASE_EN: when undefined, phase capture is
// removed, phase_cnt/phase_miss read 0 and clk_in_phase is ignored.
module clk_monitor
  import clk_mon_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clk_in_ref,
  input  logic             clk_in_phase,
  output logic [CNT_W-1:0] period_cnt,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] phase_cnt,
  output logic             phase_miss,
  output logic             meas_valid,
  output logic             err_timeout
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYC);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] high_tmp_q, high_tmp_d;
  logic             seen_fall_q, seen_fall_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic             meas_valid_q, meas_valid_d;
  logic             err_timeout_q, err_timeout_d;
  logic             open_win;
  logic             ref_rise, ref_fall;

  // Reference clock synchroniser and edge detector
  clk_mon_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ref_sync (
    .clk (clk),
    .rst (rst),
    .din (clk_in_ref),
    .rise(ref_rise),
    .fall(ref_fall)
  );

`ifdef CLK_MON_PHASE_EN
  logic             ph_rise, ph_fall_unused;
  logic             seen_ph_q, seen_ph_d;
  logic [CNT_W-1:0] phase_tmp_q, phase_tmp_d;
  logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;
  logic             phase_miss_q, phase_miss_d;

  // Phase clock path, identical depth so relative timing is preserved
  clk_mon_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ph_sync (
    .clk (clk),
    .rst (rst),
    .din (clk_in_phase),
    .rise(ph_rise),
    .fall(ph_fall_unused)
  );
`else
  logic unused_phase;
  assign unused_phase = clk_in_phase;
`endif

  // Next-state, counter and capture logic
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    high_tmp_d    = high_tmp_q;
    seen_fall_d   = seen_fall_q;
    period_cnt_d  = period_cnt_q;
    high_cnt_d    = high_cnt_q;
    meas_valid_d  = 1'b0;
    err_timeout_d = 1'b0;
    open_win      = 1'b0;
`ifdef CLK_MON_PHASE_EN
    seen_ph_d     = seen_ph_q;
    phase_tmp_d   = phase_tmp_q;
    phase_cnt_d   = phase_cnt_q;
    phase_miss_d  = phase_miss_q;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en) state_d = ARM;
      end

      ARM: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (ref_rise) begin
          open_win = 1'b1;
        end else if (cnt_q == TMO) begin
          err_timeout_d = 1'b1;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      MEAS: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (ref_rise) begin
          // Closing rise publishes the window and opens the next one in the same cycle
          period_cnt_d = cnt_q;
          high_cnt_d   = high_tmp_q;
          meas_valid_d = 1'b1;
`ifdef CLK_MON_PHASE_EN
          phase_cnt_d  = seen_ph_q ? phase_tmp_q : '0;
          phase_miss_d = ~seen_ph_q;
`endif
          open_win     = 1'b1;
        end else if (cnt_q == TMO) begin
          err_timeout_d = 1'b1;
          cnt_d         = '0;
          state_d       = ARM;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (ref_fall && !seen_fall_q) begin
            high_tmp_d  = cnt_q;
            seen_fall_d = 1'b1;
          end
`ifdef CLK_MON_PHASE_EN
          if (ph_rise && !seen_ph_q) begin
            phase_tmp_d = cnt_q;
            seen_ph_d   = 1'b1;
          end
`endif
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Window opening: a coincident phase rise belongs to the new window at lag 0
    if (open_win) begin
      state_d     = MEAS;
      cnt_d       = CNT_W'(1);
      high_tmp_d  = '0;
      seen_fall_d = 1'b0;
`ifdef CLK_MON_PHASE_EN
      seen_ph_d   = ph_rise;
      phase_tmp_d = '0;
`endif
    end
  end

  // State, counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      high_tmp_q    <= '0;
      seen_fall_q   <= 1'b0;
      period_cnt_q  <= '0;
      high_cnt_q    <= '0;
      meas_valid_q  <= 1'b0;
      err_timeout_q <= 1'b0;
`ifdef CLK_MON_PHASE_EN
      seen_ph_q     <= 1'b0;
      phase_tmp_q   <= '0;
      phase_cnt_q   <= '0;
      phase_miss_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      high_tmp_q    <= high_tmp_d;
      seen_fall_q   <= seen_fall_d;
      period_cnt_q  <= period_cnt_d;
      high_cnt_q    <= high_cnt_d;
      meas_valid_q  <= meas_valid_d;
      err_timeout_q <= err_timeout_d;
`ifdef CLK_MON_PHASE_EN
      seen_ph_q     <= seen_ph_d;
      phase_tmp_q   <= phase_tmp_d;
      phase_cnt_q   <= phase_cnt_d;
      phase_miss_q  <= phase_miss_d;
`endif
    end
  end

  assign period_cnt  = period_cnt_q;
  assign high_cnt    = high_cnt_q;
  assign meas_valid  = meas_valid_q;
  assign err_timeout = err_timeout_q;
`ifdef CLK_MON_PHASE_EN
  assign phase_cnt   = phase_cnt_q;
  assign phase_miss  = phase_miss_q;
`else
  assign phase_cnt   = '0;
  assign phase_miss  = 1'b0;
`endif

endmodule

// File: tb/tb_clk_monitor.sv
// Scoreboard bench for clk_monitor: a reference/phase waveform generator pushes
// the expected result of every completed reference cycle; a monitor pops and
// compares on each meas_valid strobe.
module tb_clk_monitor;

  localparam int unsigned CNT_W = 16;
  localparam int          TMO   = 50;
`ifdef CLK_MON_PHASE_EN
  localparam bit PH_EN = 1'b1;
`else
  localparam bit PH_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             ref_in;
  logic             ph_in;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] phase_cnt;
  logic             phase_miss;
  logic             meas_valid;
  logic             err_timeout;

  typedef struct {
    int period;
    int high;
    int phase;
    int miss;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_valid_cyc = -1000;
  int   n_tmo = 0;

  always #5 clk = ~clk;

  clk_monitor #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(2),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .clk_in_ref  (ref_in),
    .clk_in_phase(ph_in),
    .period_cnt  (period_cnt),
    .high_cnt    (high_cnt),
    .phase_cnt   (phase_cnt),
    .phase_miss  (phase_miss),
    .meas_valid  (meas_valid),
    .err_timeout (err_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive n reference periods (period p, high h) and a phase copy lagging by l;
  // every rise after the first closes a window whose result is queued.
  task automatic run_ref(input int p, input int h, input int l, input int n, input bit ph_on);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < p; c++) begin
        @(negedge clk);
        ref_in = (c < h);
        ph_in  = ph_on && (((c - l + p) % p) < h);
        if (c == 0 && k > 0) begin
          e.period = p;
          e.high   = h;
          e.phase  = (PH_EN && ph_on) ? l : 0;
          e.miss   = (PH_EN && !ph_on) ? 1 : 0;
          sb_q.push_back(e);
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag, input int p, input int h, input int ph, input int miss);
    check({tag, "_period"}, 32'(period_cnt), p);
    check({tag, "_high"}, 32'(high_cnt), h);
    check({tag, "_phase"}, 32'(phase_cnt), ph);
    check({tag, "_miss"}, 32'(phase_miss), miss);
    check({tag, "_valid"}, 32'(meas_valid), 0);
    check({tag, "_tmo"}, 32'(err_timeout), 0);
  endtask

  // Result monitor: pops the scoreboard on strobes and times timeouts against the last strobe
  always @(posedge clk) begin
    cyc++;
    #1;
    if (meas_valid === 1'b1) begin
      last_valid_cyc = cyc;
      check("sb_avail", 32'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check("period", 32'(period_cnt), mon_e.period);
        check("high", 32'(high_cnt), mon_e.high);
        check("phase", 32'(phase_cnt), mon_e.phase);
        check("miss", 32'(phase_miss), mon_e.miss);
      end
    end
    if (err_timeout === 1'b1) begin
      n_tmo++;
      check("tmo_delay", cyc - last_valid_cyc, TMO);
    end
  end

  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    ref_in = 1'b0;
    ph_in  = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs("reset", 0, 0, 0, 0);
    rst = 1'b0;
    en  = 1'b1;

    // Period 10, high 5, lag 4
    run_ref(10, 5, 4, 4, 1'b1);

    // en dropped mid-window: no strobe, results hold
    en = 1'b0;
    repeat (4) @(negedge clk);
    check_outputs("hold", 10, 5, PH_EN ? 4 : 0, 0);
    en = 1'b1;

    // Period 12, high 3, lag 0 (phase rise coincides with window-opening rise)
    run_ref(12, 3, 0, 4, 1'b1);
    en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;

    // Phase input held low
    run_ref(10, 5, 4, 3, 1'b0);
    en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;

    // Reference stops after this run: expect a timeout, then a restart
    run_ref(10, 5, 4, 3, 1'b1);
    for (int i = 0; i < 150 && n_tmo == 0; i++) @(negedge clk);
    check("tmo_seen", n_tmo, 1);
    repeat (5) @(negedge clk);
    run_ref(12, 3, 0, 3, 1'b1);

    // Reset in the middle of an open window
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_outputs("midrst", 0, 0, 0, 0);
    rst = 1'b0;
    run_ref(10, 5, 4, 3, 1'b1);

    en = 1'b0;
    repeat (10) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    check("tmo_count", n_tmo, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
